lsu_controller: RTL
===================

// Module: lsu_controller
//
// PURPOSE
// Load/store sequencer between the core's memory-control signals (mem_write,
// mem_type, mem_sign from main_decoder) and a word-wide data-memory bus with a
// req/ack handshake. Generates byte enables and shifts write data into the
// correct byte lanes. Splits misaligned accesses into two aligned bus
// transactions and reassembles and extends load data. Stalls the core until
// the access finishes, and aborts with an error flag if the bus does not
// answer in time.
//
// PARAMETERS
// TIMEOUT_CYCLES  16  max bus_req_o cycles per transaction without bus_ack_i; 0 = no timeout
//
// PORTS
// clk_i         in   1   clock; all state changes on rising edge
// rst_n_i       in   1   async active-low reset
// req_i         in   1   core access request; held high until done_o
// we_i          in   1   1 = store, 0 = load
// addr_i        in   32  byte address
// wdata_i       in   32  store data, right-aligned
// mem_type_i    in   2   00 byte, 01 half, 10 word, 11 treated as word
// mem_sign_i    in   1   1 = sign-extend load, 0 = zero-extend
// rdata_o       out  32  extended load data; valid while done_o
// done_o        out  1   one-cycle completion pulse
// err_o         out  1   high with done_o if the access timed out
// stall_o       out  1   req_i & ~done_o (combinational)
// bus_req_o     out  1   bus transaction request
// bus_we_o      out  1   bus write
// bus_addr_o    out  32  word-aligned address ([1:0] = 00)
// bus_be_o      out  4   byte enables
// bus_wdata_o   out  32  lane-aligned store data
// bus_rdata_i   in   32  read data; valid in the bus_ack_i cycle
// bus_ack_i     in   1   transaction complete
//
// BEHAVIOUR
// - Reset: state IDLE; timer 0; all outputs 0. The reset is asynchronous, so
//   bus_req_o drops immediately mid-transaction. No done_o is issued for an
//   aborted access.
// - FSM states: IDLE, ACC0, ACC1, DONE.
// - IDLE: when req_i is sampled high, register we, addr, wdata, type and sign,
//   then go to ACC0. Later changes on the core-side inputs are ignored.
// - Offset and split rule (off = addr[1:0]):
//   - Byte: never splits.
//   - Half: splits when off = 3.
//   - Word: splits when off != 0.
// - ACC0 byte enables:
//   - Byte: be0 = 0001 << off.
//   - Half: be0 = (0011 << off) & 1111.
//   - Word: be0 = (1111 << off) & 1111.
// - ACC1 byte enables, split accesses only: be1 = lane mask of the remaining
//   bytes.
//   - Half, off 3: 0001.
//   - Word: 0001, 0011 or 0111 for off 1, 2 or 3.
// - bus_wdata_o = wdata rotated left by 8*off, the same value in both accesses.
// - bus_addr_o = {addr[31:2], 00} in ACC0 and that value + 4 in ACC1. A 32-bit
//   wrap at 0xFFFFFFFC + 4 gives 0x00000000.
// - Bus handshake: bus_req_o, bus_we_o, bus_addr_o, bus_be_o and bus_wdata_o are
//   registered. They are high or stable for the whole of ACC0/ACC1 until the
//   bus_ack_i edge. On the ack edge, enabled lanes of bus_rdata_i are merged
//   into a 32-bit buffer. ACC0 then goes to ACC1 if split, else to DONE. ACC1
//   goes to DONE.
// - The bus deasserts bus_req_o for at least one cycle between the ACC0 and
//   ACC1 transactions.
// - Timer: cleared on entry to ACC0/ACC1 and increments each cycle without ack.
//   When TIMEOUT_CYCLES != 0 and timer = TIMEOUT_CYCLES-1 with no ack, go to
//   DONE with err_o = 1 and rdata_o = 0. An ack in that same cycle wins.
// - DONE: done_o = 1 for exactly one cycle, then IDLE. Load result: buffer
//   rotated right by 8*off, masked to 8/16/32 bits, then sign- or zero-extended.
//   rdata_o = 0 for stores. A new req_i is accepted in the cycle after DONE at
//   the earliest.
// - Latency: aligned access with ack in the first bus cycle gives done_o 2
//   cycles after req_i is sampled. A split access adds at least 2 cycles.
// - rdata_o and err_o are 0 outside DONE.
//
// TESTING
// 1. LW at 0x100, ack 3 cycles after bus_req_o, bus_rdata 0xDEADBEEF
//    -> bus_addr 0x100, be 1111, one transaction, rdata_o 0xDEADBEEF.
// 2. LB at 0x103 with sign=1, bus_rdata 0x80000000 -> be 1000, rdata_o 0xFFFFFF80.
//    Same access with sign=0 -> rdata_o 0x00000080.
// 3. SW 0x11223344 at 0x102 -> txn 1: addr 0x100, be 1100, wdata 0x33441122.
//    txn 2: addr 0x104, be 0011, same wdata. done_o after txn 2.
// 4. LH at 0x103 with sign=1; txn 1 (0x100, be 1000) returns 0xAB000000, txn 2
//    (0x104, be 0001) returns 0x000000CD -> rdata_o 0xFFFFCDAB.
// 5. TIMEOUT_CYCLES=8, LW, bus_ack_i never asserted -> bus_req_o high for 8
//    cycles, then done_o=1, err_o=1, rdata_o=0; next request proceeds normally.
// 6. Assert rst_n_i low during ACC1 of a misaligned SW -> bus_req_o 0
//    immediately, no done_o, and a following aligned LW completes correctly.

Source files
------------

// File: rtl/lsu_controller_if.sv
// Word-wide data-memory bus between the load/store sequencer and memory.
// Signals:
//   bus_req   request, held high until bus_ack
//   bus_we    1 = write
//   bus_addr  word-aligned byte address
//   bus_be    byte-lane enables
//   bus_wdata lane-aligned write data
//   bus_rdata read data, valid in the bus_ack cycle
//   bus_ack   transaction complete
// Modports: master (sequencer side), slave (memory side).
interface lsu_controller_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack
  );
endinterface

// File: rtl/lsu_controller.sv
// Load/store sequencer between core memory-control signals and a word-wide
// req/ack data bus. Places store data in byte lanes, generates byte enables,
// splits misaligned accesses into two aligned transactions, reassembles and
// extends load data, and aborts with an error if the bus does not answer.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   req_i            core request, held until done_o
//   we_i             1 = store
//   addr_i, wdata_i  byte address, right-aligned store data
//   mem_type_i       00 byte, 01 half, 1x word
//   mem_sign_i       1 = sign-extend load
//   rdata_o          extended load data, valid with done_o
//   done_o, err_o    completion pulse, timeout flag
//   stall_o          req_i & ~done_o
//   bus              data-memory bus (master modport)
module lsu_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  mem_type_i,
  input  logic        mem_sign_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  lsu_controller_if.master bus
);

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StDone} state_e;

  localparam logic [31:0] TimeoutLast =
      (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [31:0] timer_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [1:0]  type_q;
  logic        sign_q;
  logic [31:0] buf_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] merged;
  logic [31:0] rot;
  logic [31:0] load_val;
  logic        split;
  logic        timeout_hit;

  function automatic logic [3:0] be_first(input logic [1:0] mtype, input logic [1:0] off);
    logic [3:0] be;
    case (mtype)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111 << off;
    endcase
    return be;
  endfunction

  // Lanes left over for the second transaction of a split access.
  function automatic logic [3:0] be_second(input logic [1:0] mtype, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    if (mtype == 2'b01) begin
      be = 4'b0001;
    end else if (mtype[1]) begin
      case (off)
        2'd1:    be = 4'b0001;
        2'd2:    be = 4'b0011;
        2'd3:    be = 4'b0111;
        default: be = 4'b0000;
      endcase
    end
    return be;
  endfunction

  function automatic logic needs_split(input logic [1:0] mtype, input logic [1:0] off);
    logic s;
    case (mtype)
      2'b00:   s = 1'b0;
      2'b01:   s = (off == 2'd3);
      default: s = (off != 2'd0);
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rotl8(input logic [31:0] w, input logic [1:0] off);
    logic [63:0] t;
    t = {w, w} << {off, 3'b000};
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr8(input logic [31:0] w, input logic [1:0] off);
    logic [63:0] t;
    t = {w, w} >> {off, 3'b000};
    return t[31:0];
  endfunction

  always_comb begin
    merged = buf_q;
    for (int i = 0; i < 4; i++) begin
      if (bus_be_q[i]) begin
        merged[8*i +: 8] = bus.bus_rdata[8*i +: 8];
      end
    end
    rot = rotr8(merged, off_q);
    case (type_q)
      2'b00:   load_val = sign_q ? {{24{rot[7]}}, rot[7:0]} : {24'd0, rot[7:0]};
      2'b01:   load_val = sign_q ? {{16{rot[15]}}, rot[15:0]} : {16'd0, rot[15:0]};
      default: load_val = rot;
    endcase
    split       = needs_split(type_q, off_q);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TimeoutLast);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      type_q      <= '0;
      sign_q      <= 1'b0;
      buf_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      // Completion outputs are only ever high for the single DONE cycle.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        StIdle: begin
          if (req_i) begin
            we_q        <= we_i;
            off_q       <= addr_i[1:0];
            type_q      <= mem_type_i;
            sign_q      <= mem_sign_i;
            buf_q       <= '0;
            timer_q     <= '0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= we_i;
            bus_addr_q  <= {addr_i[31:2], 2'b00};
            bus_be_q    <= be_first(mem_type_i, addr_i[1:0]);
            bus_wdata_q <= rotl8(wdata_i, addr_i[1:0]);
            state_q     <= StAcc0;
          end
        end
        StAcc0, StAcc1: begin
          if (!bus_req_q) begin
            // Idle gap before the second transaction of a split access.
            bus_req_q <= 1'b1;
          end else if (bus.bus_ack) begin
            buf_q     <= merged;
            bus_req_q <= 1'b0;
            timer_q   <= '0;
            if (state_q == StAcc0 && split) begin
              bus_addr_q <= bus_addr_q + 32'd4;
              bus_be_q   <= be_second(type_q, off_q);
              state_q    <= StAcc1;
            end else begin
              done_q  <= 1'b1;
              rdata_q <= we_q ? 32'd0 : load_val;
              state_q <= StDone;
            end
          end else if (timeout_hit) begin
            bus_req_q <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
            state_q   <= StDone;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~done_q;

endmodule
